// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
//   state_e       : frame-parsing FSM states
//   MagicDefault  : default frame start byte
//   LenW          : width of the frame word-count field
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
      StChk,
      StDone,
      StErr
   } state_e;

   localparam logic [7:0]  MagicDefault = 8'hA5;
   localparam int unsigned LenW         = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   i_rx_valid / i_rx_data : one-cycle strobe plus received byte
//   o_we / o_waddr / o_wdata : one-cycle word write into instruction memory
// master = loader side, slave = the environment (UART receiver + memory).
interface imem_loader_if;

   logic        i_rx_valid;
   logic [7:0]  i_rx_data;
   logic        o_we;
   logic [31:0] o_waddr;
   logic [31:0] o_wdata;

   modport master (
      input  i_rx_valid,
      input  i_rx_data,
      output o_we,
      output o_waddr,
      output o_wdata
   );

   modport slave (
      output i_rx_valid,
      output i_rx_data,
      input  o_we,
      input  o_waddr,
      input  o_wdata
   );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs payload bytes (least-significant first) into 32-bit words.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clear_i        : restart byte counting at a new frame
//   byte_valid_i   : byte_i is a payload byte to consume this cycle
//   byte_i         : payload byte
//   byte_last_o    : the next consumed byte completes a word
//   word_valid_o   : one-cycle pulse, cycle after the 4th byte of a word
//   word_o         : assembled word; holds until the next word completes
module imem_loader_word_assembler (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_last_o,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;
   logic [31:0] word_q, word_d;
   logic        valid_q, valid_d;

   assign byte_last_o  = (cnt_q == 2'd3);
   assign word_valid_o = valid_q;
   assign word_o       = word_q;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (byte_valid_i) begin
         // Shift down so the first byte ends up in the low lane.
         shift_d = {byte_i, shift_q[23:8]};
         cnt_d   = cnt_q + 2'd1;
         if (cnt_q == 2'd3) begin
            // Separate output register so o_wdata holds while the next word fills.
            word_d  = {byte_i, shift_q};
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer. Parses MAGIC, LEN_LO, LEN_HI,
// LEN x 4 payload bytes, CHK from a byte stream and writes each word.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus            : byte input and memory write port (master modport)
//   o_cpu_rst_n    : core reset, released only after a good load
//   o_busy         : frame in progress
//   o_done / o_err : outcome of the last load (level)
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned N           = 2048,
   parameter logic [7:0]  MAGIC       = MagicDefault,
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   imem_loader_if.master bus,
   output logic          o_cpu_rst_n,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_err
);

   localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);

   state_e            state_q, state_d;
   logic [LenW-1:0]   len_q, len_d;
   logic [LenW-1:0]   idx_q, idx_d;
   logic [7:0]        sum_q, sum_d;
   logic [IdleW-1:0]  idle_q, idle_d;
   logic [31:0]       waddr_q, waddr_d;

   logic              rx;
   logic [7:0]        rx_byte;
   logic              start;
   logic              data_byte;
   logic              byte_last;
   logic              word_valid;
   logic [31:0]       word;
   logic [LenW-1:0]   len_full;

   assign rx       = bus.i_rx_valid;
   assign rx_byte  = bus.i_rx_data;
   assign len_full = {rx_byte, len_q[7:0]};

   // MAGIC restarts a frame from any resting state.
   assign start     = rx && (rx_byte == MAGIC) &&
                      (state_q inside {StIdle, StDone, StErr});
   assign data_byte = rx && (state_q == StData);

   assign o_busy      = state_q inside {StLenLo, StLenHi, StData, StChk};
   assign o_done      = (state_q == StDone);
   assign o_err       = (state_q == StErr);
   assign o_cpu_rst_n = (state_q == StDone);

   assign bus.o_we    = word_valid;
   assign bus.o_wdata = word;
   assign bus.o_waddr = waddr_q;

   imem_loader_word_assembler u_word_asm (
      .clk_i        (i_clk),
      .rst_ni       (i_rst_n),
      .clear_i      (start),
      .byte_valid_i (data_byte),
      .byte_i       (rx_byte),
      .byte_last_o  (byte_last),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      waddr_d = waddr_q;
      idle_d  = '0;

      if (o_busy && !rx) begin
         idle_d = idle_q + 1'b1;
      end

      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StLenLo;
               sum_d   = '0;
               idx_d   = '0;
            end
         end
         StLenLo: begin
            if (rx) begin
               len_d[7:0] = rx_byte;
               state_d    = StLenHi;
            end
         end
         StLenHi: begin
            if (rx) begin
               len_d = len_full;
               if (len_full > LenW'(N)) begin
                  state_d = StErr;
               end else if (len_full == '0) begin
                  state_d = StChk;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (rx) begin
               sum_d = sum_q + rx_byte;
               if (byte_last) begin
                  // Address is captured with the word so it lines up with the pulse.
                  waddr_d = {14'b0, idx_q, 2'b00};
                  idx_d   = idx_q + 1'b1;
                  if (idx_q + 1'b1 == len_q) begin
                     state_d = StChk;
                  end
               end
            end
         end
         StChk: begin
            if (rx) begin
               state_d = (rx_byte == sum_q) ? StDone : StErr;
            end
         end
         default: state_d = StIdle;
      endcase

      if (o_busy && !rx && (idle_q == IdleW'(TIMEOUT_CYC - 1))) begin
         state_d = StErr;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         len_q   <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         idle_q  <= '0;
         waddr_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         idle_q  <= idle_d;
         waddr_q <= waddr_d;
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the word-addressed instruction memory. It receives a framed byte stream, typically from a UART receiver, and assembles little-endian 32-bit words. Each word goes out on a one-cycle write port into the instruction memory array. The CPU core is held in reset from power-up, and again during any reload, until a load completes with a good checksum.

Parameters:
N, 2048, instruction memory depth in 32-bit words; the maximum accepted word count (must be ≤ 65535)
MAGIC, 8'hA5, frame start byte
TIMEOUT_CYC, 1_000_000, idle cycles allowed between bytes inside a frame before the load aborts

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, synchronous, active-low
i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a new byte
i_rx_data  in  8  received byte
o_we  out  1  instruction memory write enable, one-cycle pulse
o_waddr  out  32  byte address, word-aligned (bits [1:0] = 0)
o_wdata  out  32  word to write
o_cpu_rst_n  out  1  core reset, active-low; 0 = core held in reset
o_busy  out  1  a frame is in progress
o_done  out  1  last load succeeded; level output
o_err  out  1  last load failed; level output

Behaviour:
- Reset is synchronous and active-low on i_clk. All outputs reset to 0, so the core is held in reset after power-up. State resets to IDLE and all counters clear.
- Frame format: MAGIC, LEN_LO, LEN_HI, then LEN×4 payload bytes (least-significant byte of each word first), then CHK.
- CHK = sum of all payload bytes mod 256. Header bytes are not included.
- A byte is consumed only in a cycle where i_rx_valid=1. No back-pressure: at most one byte per cycle is accepted.
- States:
  - IDLE: a byte equal to MAGIC → LEN_LO; other bytes are ignored.
  - LEN_LO: store LEN[7:0] → LEN_HI.
  - LEN_HI: store LEN[15:8]; if LEN > N → ERR; if LEN = 0 → CHK; otherwise → DATA.
  - DATA: shift each byte into the word register; the byte counter wraps 0..3. After the 4th byte of the last word → CHK.
  - CHK: byte equals the running sum → DONE; otherwise → ERR.
  - DONE: MAGIC → LEN_LO (reload); other bytes are ignored.
  - ERR: MAGIC → LEN_LO (reload); other bytes are ignored.
- Write timing: the 4th byte of word k is accepted at cycle t. At t+1, o_we=1 for exactly one cycle, o_waddr = k<<2 and o_wdata = {b3,b2,b1,b0}. The word index then increments.
- o_wdata and o_waddr hold their values outside the write pulse.
- o_cpu_rst_n: 0 in every state except DONE. It drops to 0 in the cycle after MAGIC is accepted from DONE. It rises to 1 in the cycle after a good CHK.
- o_busy = 1 in LEN_LO, LEN_HI, DATA and CHK.
- o_done = 1 only in DONE. o_err = 1 only in ERR. Both clear when MAGIC is accepted.
- Timeout: the idle counter runs while o_busy=1 and clears on each accepted byte. Reaching TIMEOUT_CYC → ERR.
- Failed loads: words already written stay in memory; there is no rollback. The core stays in reset until a good load.
- A write pulse pending at the moment of a state change to ERR is still issued.
- i_rst_n low mid-frame: the frame is abandoned, o_we=0 the next cycle, all outputs return to reset values.
- Sum and counter arithmetic: the checksum is 8-bit wrap-around. The word index is 16-bit. o_waddr = {14'b0, idx, 2'b00}.

Decomposition:
- Package imem_loader_pkg holds:
  - state enum: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR;
  - default MAGIC constant;
  - LEN width (16) constant.
- One sub-module, word_assembler, handles byte shifting and the 2-bit byte counter, and emits a word_valid pulse with the assembled 32-bit word. The FSM, checksum, timeout and address generation live in the top level.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles, then release with no bytes → o_cpu_rst_n=0, o_we=0, o_done=0, o_err=0, o_busy=0.
- Good load: send A5 02 00 13 00 50 00 93 00 10 00 06 → writes (addr 0x0, data 0x00500013) and (addr 0x4, data 0x00100093), one o_we pulse each. o_done=1, and o_cpu_rst_n=1 one cycle after the CHK byte.
- Bad checksum: same frame with CHK=07 → both writes occur, o_err=1, o_cpu_rst_n stays 0.
- Oversize: A5 01 08 (LEN=0x0801 > 2048) → ERR immediately after LEN_HI, no o_we.
- Zero length and noise: bytes 11 22 before A5 00 00 00 → noise ignored in IDLE, no writes, DONE.
- Timeout and reload: A5 01 00 13, then idle TIMEOUT_CYC cycles → ERR. Then a full good 1-word frame → o_err clears on A5, DONE, core released. From DONE, send A5 again → o_cpu_rst_n falls to 0 the next cycle.
